lsu_agu_arb: RTL and testbench
==============================

# lsu_agu_arb

Shares one LSU address-generation adder between the load-issue and store-issue paths of the HeHe core LSU. Each cycle it grants at most one requester by round-robin, computes the virtual address as base + offset truncated to VIRTUAL_ADDR_LEN, and checks alignment for the access size. The result goes into a single-entry output register with a valid/ready handshake toward the DTLB/cache-request stage. The block sits between the load/store queue issue logic and the downstream translation stage.

## Interface
- XLEN, 64, operand width of base and offset
- VIRTUAL_ADDR_LEN, 39, generated address width
- TAG_WIDTH, 6, LSQ entry tag carried with each request
- clk  input  1  clock, all state updates on rising edge
- rstn  input  1  reset; one clock, synchronous, active-low
- flush_i  input  1  pipeline flush; kills held result and same-cycle acceptance
- ld_req_valid_i  input  1  load requester has an op
- ld_req_ready_o  output  1  load op accepted this cycle (valid & ready)
- ld_base_i / ld_offset_i  input  XLEN each  load operands
- ld_size_i  input  2  0=byte 1=half 2=word 3=dword
- ld_tag_i  input  TAG_WIDTH  load tag
- st_req_valid_i, st_req_ready_o, st_base_i, st_offset_i, st_size_i, st_tag_i  same as load set, for stores
- agu_valid_o  output  1  output register holds a result
- agu_ready_i  input  1  downstream accepts result
- agu_addr_o  output  VIRTUAL_ADDR_LEN  generated address
- agu_is_store_o  output  1  result came from store requester
- agu_size_o  output  2  size of held op
- agu_tag_o  output  TAG_WIDTH  tag of held op
- agu_misalign_o  output  1  address not naturally aligned for size

## Operation
- Address: base[VIRTUAL_ADDR_LEN-1:0] + offset[VIRTUAL_ADDR_LEN-1:0], modulo 2^VIRTUAL_ADDR_LEN; upper operand bits ignored, carry out discarded.
- Misalign: size 0 never; 1 if addr[0]; 2 if addr[1:0]!=0; 3 if addr[2:0]!=0. Flag is reported, and the op is still passed downstream.
- Slot free = !agu_valid_o | agu_ready_i. Accept = slot free & !flush_i & some valid.
- Arbitration: priority bit prio (0=load, 1=store). Only one valid: grant it. Both valid: grant prio side. After every grant, prio points to the non-granted class (load grant -> prio=1, store grant -> prio=0). prio is unchanged if no grant.
- ld_req_ready_o / st_req_ready_o are high only for the granted side, combinationally, in the accept cycle. At most one is high per cycle.
- Output register loads addr, is_store, size, tag and misalign on accept. agu_valid_o: set on accept. It clears when the held result is taken (agu_ready_i) and nothing new is accepted, and it clears on flush_i.
- Held outputs are stable while agu_valid_o & !agu_ready_i.
- Flush: agu_valid_o goes to 0 next cycle, both ready_o are 0 in the flush cycle, and prio is unchanged.

## Timing
- Latency 1 cycle: op accepted in cycle N appears with agu_valid_o=1 in cycle N+1.
- Throughput 1 op/cycle with agu_ready_i held high. Back-to-back replace in the same cycle is allowed (take and load).
- Reset (rstn=0 at edge): agu_valid_o=0, agu_addr_o=0, agu_is_store_o=0, agu_size_o=0, agu_tag_o=0, agu_misalign_o=0, prio=0. ready outputs are 0 while rstn=0.
- Reset mid-operation drops the held result without handshake. Requesters must re-present.
- Downstream stall: agu_ready_i=0 with agu_valid_o=1 forces both ready_o to 0, and prio does not advance.

## Test plan
- Single load: base=0x1000, offset=0x24, size=2, tag=5 -> ld_req_ready_o=1 in cycle N; cycle N+1 agu_valid_o=1, addr=0x1024, is_store=0, misalign=0, tag=5.
- Contention: both valid every cycle for 4 cycles, agu_ready_i=1, after reset -> grants L,S,L,S; tags emerge in that order one per cycle.
- Stall: agu_valid_o=1, agu_ready_i=0 for 3 cycles with both requesters valid -> both ready_o=0, outputs stable, prio unchanged; on release, the prio side is granted in the same cycle.
- Wrap/misalign: base=0x7F_FFFF_FFFF, offset=0x3, size=3 -> addr=0x2 (39-bit wrap), misalign=1; base=0x10, offset=0x1, size=1 -> misalign=1; size=0 -> misalign=0.
- Flush: flush_i=1 while holding a result and with a load valid -> ld_req_ready_o=0; next cycle agu_valid_o=0; load is granted the cycle after flush deasserts.
- Reset mid-op: rstn=0 for one cycle while agu_valid_o=1 -> all outputs 0 next cycle, prio=0; first contended grant after reset goes to the load requester.

Source files
------------

// File: rtl/lsu_agu_arb.sv
// Shared LSU address-generation unit: round-robin arbitration between the load and
// store issue paths, address add with alignment check, single-entry output register.
module lsu_agu_arb #(
  parameter int unsigned XLEN             = 64,
  parameter int unsigned VIRTUAL_ADDR_LEN = 39,
  parameter int unsigned TAG_WIDTH        = 6
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        flush_i,

  input  logic                        ld_req_valid_i,
  output logic                        ld_req_ready_o,
  input  logic [XLEN-1:0]             ld_base_i,
  input  logic [XLEN-1:0]             ld_offset_i,
  input  logic [1:0]                  ld_size_i,
  input  logic [TAG_WIDTH-1:0]        ld_tag_i,

  input  logic                        st_req_valid_i,
  output logic                        st_req_ready_o,
  input  logic [XLEN-1:0]             st_base_i,
  input  logic [XLEN-1:0]             st_offset_i,
  input  logic [1:0]                  st_size_i,
  input  logic [TAG_WIDTH-1:0]        st_tag_i,

  output logic                        agu_valid_o,
  input  logic                        agu_ready_i,
  output logic [VIRTUAL_ADDR_LEN-1:0] agu_addr_o,
  output logic                        agu_is_store_o,
  output logic [1:0]                  agu_size_o,
  output logic [TAG_WIDTH-1:0]        agu_tag_o,
  output logic                        agu_misalign_o
);

  localparam int unsigned VA_W = VIRTUAL_ADDR_LEN;

  // prio: 0 = load wins a tie, 1 = store wins a tie
  logic                 prio;
  logic                 slot_free;
  logic                 accept;
  logic                 grant_st;
  logic [VA_W-1:0]      sel_base;
  logic [VA_W-1:0]      sel_offset;
  logic [VA_W-1:0]      sum;
  logic [1:0]           sel_size;
  logic [TAG_WIDTH-1:0] sel_tag;
  logic                 misalign;

  // Arbitration and handshake; rstn gates acceptance so ready stays low in reset
  always_comb begin
    slot_free      = !agu_valid_o || agu_ready_i;
    accept         = rstn && slot_free && !flush_i && (ld_req_valid_i || st_req_valid_i);
    grant_st       = st_req_valid_i && (!ld_req_valid_i || prio);
    ld_req_ready_o = accept && !grant_st;
    st_req_ready_o = accept && grant_st;
  end

  // Operand mux feeding the single shared adder; upper operand bits are dropped
  always_comb begin
    sel_base   = grant_st ? st_base_i[VA_W-1:0]   : ld_base_i[VA_W-1:0];
    sel_offset = grant_st ? st_offset_i[VA_W-1:0] : ld_offset_i[VA_W-1:0];
    sel_size   = grant_st ? st_size_i : ld_size_i;
    sel_tag    = grant_st ? st_tag_i  : ld_tag_i;
    sum        = sel_base + sel_offset;
    misalign   = 1'b0;
    case (sel_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = sum[0];
      2'd2:    misalign = |sum[1:0];
      default: misalign = |sum[2:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      prio           <= 1'b0;
      agu_valid_o    <= 1'b0;
      agu_addr_o     <= '0;
      agu_is_store_o <= 1'b0;
      agu_size_o     <= 2'd0;
      agu_tag_o      <= '0;
      agu_misalign_o <= 1'b0;
    end else if (flush_i) begin
      agu_valid_o <= 1'b0;
    end else if (accept) begin
      // Next tie goes to the class that just lost
      prio           <= !grant_st;
      agu_valid_o    <= 1'b1;
      agu_addr_o     <= sum;
      agu_is_store_o <= grant_st;
      agu_size_o     <= sel_size;
      agu_tag_o      <= sel_tag;
      agu_misalign_o <= misalign;
    end else if (agu_ready_i) begin
      agu_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lsu_agu_arb.sv
// Scoreboard bench for lsu_agu_arb: stimulus pushes expected results, a monitor
// pops and compares on every output handshake.
module tb_lsu_agu_arb;

  localparam int unsigned XLEN = 64;
  localparam int unsigned VA   = 39;
  localparam int unsigned TW   = 6;

  typedef struct packed {
    logic [VA-1:0] addr;
    logic          is_store;
    logic [1:0]    size;
    logic [TW-1:0] tag;
    logic          mis;
  } exp_t;

  logic            clk = 1'b0;
  logic            rstn, flush_i;
  logic            ld_req_valid_i, ld_req_ready_o;
  logic [XLEN-1:0] ld_base_i, ld_offset_i;
  logic [1:0]      ld_size_i;
  logic [TW-1:0]   ld_tag_i;
  logic            st_req_valid_i, st_req_ready_o;
  logic [XLEN-1:0] st_base_i, st_offset_i;
  logic [1:0]      st_size_i;
  logic [TW-1:0]   st_tag_i;
  logic            agu_valid_o, agu_ready_i;
  logic [VA-1:0]   agu_addr_o;
  logic            agu_is_store_o;
  logic [1:0]      agu_size_o;
  logic [TW-1:0]   agu_tag_o;
  logic            agu_misalign_o;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  lsu_agu_arb #(.XLEN(XLEN), .VIRTUAL_ADDR_LEN(VA), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rstn(rstn), .flush_i(flush_i),
    .ld_req_valid_i(ld_req_valid_i), .ld_req_ready_o(ld_req_ready_o),
    .ld_base_i(ld_base_i), .ld_offset_i(ld_offset_i), .ld_size_i(ld_size_i), .ld_tag_i(ld_tag_i),
    .st_req_valid_i(st_req_valid_i), .st_req_ready_o(st_req_ready_o),
    .st_base_i(st_base_i), .st_offset_i(st_offset_i), .st_size_i(st_size_i), .st_tag_i(st_tag_i),
    .agu_valid_o(agu_valid_o), .agu_ready_i(agu_ready_i), .agu_addr_o(agu_addr_o),
    .agu_is_store_o(agu_is_store_o), .agu_size_o(agu_size_o), .agu_tag_o(agu_tag_o),
    .agu_misalign_o(agu_misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [VA-1:0] a, input logic s, input logic [1:0] sz,
                              input logic [TW-1:0] t, input logic m);
    exp_t e;
    e.addr = a; e.is_store = s; e.size = sz; e.tag = t; e.mis = m;
    return e;
  endfunction

  // Monitor: every downstream handshake must match the oldest expected result
  initial begin
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (rstn && agu_valid_o && agu_ready_i && !flush_i) begin
        got = mk(agu_addr_o, agu_is_store_o, agu_size_o, agu_tag_o, agu_misalign_o);
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 64'(got), 64'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_op{addr,st,size,tag,mis}", 64'(got), 64'(e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ld(input logic v, input logic [63:0] b, input logic [63:0] o,
                        input logic [1:0] sz, input logic [TW-1:0] t);
    ld_req_valid_i = v; ld_base_i = b; ld_offset_i = o; ld_size_i = sz; ld_tag_i = t;
  endtask

  task automatic set_st(input logic v, input logic [63:0] b, input logic [63:0] o,
                        input logic [1:0] sz, input logic [TW-1:0] t);
    st_req_valid_i = v; st_base_i = b; st_offset_i = o; st_size_i = sz; st_tag_i = t;
  endtask

  // Present a single requester into a free slot and expect it to be granted
  task automatic issue(input logic is_st, input logic [63:0] b, input logic [63:0] o,
                       input logic [1:0] sz, input logic [TW-1:0] t,
                       input logic [VA-1:0] ea, input logic em);
    if (is_st) begin
      set_ld(1'b0, 64'h0, 64'h0, 2'd0, 6'd0); set_st(1'b1, b, o, sz, t);
    end else begin
      set_st(1'b0, 64'h0, 64'h0, 2'd0, 6'd0); set_ld(1'b1, b, o, sz, t);
    end
    exp_q.push_back(mk(ea, is_st, sz, t, em));
    @(negedge clk);
    chk("issue_ld_ready", 64'(ld_req_ready_o), 64'(!is_st));
    chk("issue_st_ready", 64'(st_req_ready_o), 64'(is_st));
    tick();
  endtask

  // Both requesters valid; operand address is tag*16 so results are easy to spot
  task automatic contend(input logic [TW-1:0] lt, input logic [TW-1:0] stg, input logic exp_st);
    set_ld(1'b1, 64'(lt) << 4, 64'h0, 2'd0, lt);
    set_st(1'b1, 64'(stg) << 4, 64'h0, 2'd0, stg);
    if (exp_st) exp_q.push_back(mk(VA'(64'(stg) << 4), 1'b1, 2'd0, stg, 1'b0));
    else        exp_q.push_back(mk(VA'(64'(lt) << 4), 1'b0, 2'd0, lt, 1'b0));
    @(negedge clk);
    chk("contend_ld_ready", 64'(ld_req_ready_o), 64'(!exp_st));
    chk("contend_st_ready", 64'(st_req_ready_o), 64'(exp_st));
    tick();
  endtask

  task automatic idle_valids();
    set_ld(1'b0, 64'h0, 64'h0, 2'd0, 6'd0);
    set_st(1'b0, 64'h0, 64'h0, 2'd0, 6'd0);
  endtask

  task automatic chk_reset_outputs(input string tagname);
    chk({tagname, "_valid"}, 64'(agu_valid_o), 64'h0);
    chk({tagname, "_addr"}, 64'(agu_addr_o), 64'h0);
    chk({tagname, "_is_store"}, 64'(agu_is_store_o), 64'h0);
    chk({tagname, "_size"}, 64'(agu_size_o), 64'h0);
    chk({tagname, "_tag"}, 64'(agu_tag_o), 64'h0);
    chk({tagname, "_misalign"}, 64'(agu_misalign_o), 64'h0);
  endtask

  initial begin
    rstn = 1'b0; flush_i = 1'b0; agu_ready_i = 1'b0;
    set_ld(1'b1, 64'h100, 64'h0, 2'd0, 6'd1);
    set_st(1'b1, 64'h200, 64'h0, 2'd0, 6'd2);

    // Reset: requests present but ready must stay low
    @(negedge clk);
    chk("rst_ld_ready", 64'(ld_req_ready_o), 64'h0);
    chk("rst_st_ready", 64'(st_req_ready_o), 64'h0);
    tick();
    idle_valids();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk_reset_outputs("reset");
    tick();

    // Single load, one-cycle latency
    agu_ready_i = 1'b1;
    issue(1'b0, 64'h1000, 64'h24, 2'd2, 6'd5, 39'h1024, 1'b0);
    idle_valids();
    @(negedge clk);
    chk("single_latency_valid", 64'(agu_valid_o), 64'h1);
    tick();
    @(negedge clk);
    chk("single_drained_valid", 64'(agu_valid_o), 64'h0);
    tick();

    // Wrap and alignment, back-to-back at full throughput
    issue(1'b1, 64'hFFFF_FF7F_FFFF_FFFF, 64'h3, 2'd3, 6'd1, 39'h2, 1'b1);
    issue(1'b0, 64'h10, 64'h1, 2'd1, 6'd2, 39'h11, 1'b1);
    issue(1'b0, 64'h10, 64'h1, 2'd0, 6'd3, 39'h11, 1'b0);
    issue(1'b0, 64'h1000, 64'h2, 2'd2, 6'd4, 39'h1002, 1'b1);
    issue(1'b1, 64'h1000, 64'h8, 2'd3, 6'd6, 39'h1008, 1'b0);
    issue(1'b0, 64'h1000, 64'h2, 2'd1, 6'd7, 39'h1002, 1'b0);
    idle_valids();
    @(negedge clk);
    tick();

    // Reset mid-operation drops a held result; prio returns to load
    agu_ready_i = 1'b0;
    issue(1'b1, 64'h40, 64'h0, 2'd3, 6'd9, 39'h40, 1'b0);
    idle_valids();
    @(negedge clk);
    chk("held_before_reset", 64'(agu_valid_o), 64'h1);
    tick();
    rstn = 1'b0;
    set_ld(1'b1, 64'h80, 64'h0, 2'd0, 6'd33);
    @(negedge clk);
    chk("midrst_ld_ready", 64'(ld_req_ready_o), 64'h0);
    tick();
    rstn = 1'b1;
    idle_valids();
    if (exp_q.size() > 0) exp_q.delete(0);
    @(negedge clk);
    chk_reset_outputs("midrst");
    tick();

    // Contention after reset: L,S,L,S
    agu_ready_i = 1'b1;
    contend(6'd10, 6'd20, 1'b0);
    contend(6'd11, 6'd20, 1'b1);
    contend(6'd11, 6'd21, 1'b0);
    contend(6'd12, 6'd21, 1'b1);
    idle_valids();
    @(negedge clk);
    tick();

    // Downstream stall: prio is store after the load below, must survive the stall
    issue(1'b0, 64'h1E0, 64'h0, 2'd0, 6'd30, 39'h1E0, 1'b0);
    agu_ready_i = 1'b0;
    set_ld(1'b1, 64'h1F0, 64'h0, 2'd0, 6'd31);
    set_st(1'b1, 64'h280, 64'h0, 2'd0, 6'd40);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ld_ready", 64'(ld_req_ready_o), 64'h0);
      chk("stall_st_ready", 64'(st_req_ready_o), 64'h0);
      chk("stall_valid", 64'(agu_valid_o), 64'h1);
      chk("stall_tag", 64'(agu_tag_o), 64'd30);
      chk("stall_addr", 64'(agu_addr_o), 64'h1E0);
      tick();
    end
    agu_ready_i = 1'b1;
    exp_q.push_back(mk(39'h280, 1'b1, 2'd0, 6'd40, 1'b0));
    @(negedge clk);
    chk("release_st_ready", 64'(st_req_ready_o), 64'h1);
    chk("release_ld_ready", 64'(ld_req_ready_o), 64'h0);
    tick();
    issue(1'b0, 64'h1F0, 64'h0, 2'd0, 6'd31, 39'h1F0, 1'b0);
    idle_valids();
    @(negedge clk);
    tick();

    // Flush kills the held result and blocks acceptance in the flush cycle
    agu_ready_i = 1'b0;
    issue(1'b0, 64'h500, 64'h0, 2'd1, 6'd50, 39'h500, 1'b0);
    set_ld(1'b1, 64'h510, 64'h0, 2'd1, 6'd51);
    flush_i = 1'b1;
    @(negedge clk);
    chk("flush_ld_ready", 64'(ld_req_ready_o), 64'h0);
    chk("flush_st_ready", 64'(st_req_ready_o), 64'h0);
    tick();
    flush_i = 1'b0;
    if (exp_q.size() > 0) exp_q.delete(0);
    exp_q.push_back(mk(39'h510, 1'b0, 2'd1, 6'd51, 1'b0));
    @(negedge clk);
    chk("post_flush_valid", 64'(agu_valid_o), 64'h0);
    chk("post_flush_ld_ready", 64'(ld_req_ready_o), 64'h1);
    tick();
    idle_valids();
    agu_ready_i = 1'b1;
    @(negedge clk);
    chk("post_flush_result_valid", 64'(agu_valid_o), 64'h1);
    tick();
    @(negedge clk);
    chk("final_valid", 64'(agu_valid_o), 64'h0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
